// File: rtl/qspi_pkg.sv
// Shared opcodes, FSM state encoding and continuous-read mode pattern
// for the QSPI flash responder.
package qspi_pkg;

    localparam logic [7:0] OP_RDP   = 8'hAB;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_WRSR  = 8'h01;
    localparam logic [7:0] OP_QREAD = 8'hEB;

    // Mode byte bits [5:4] that keep the device in continuous-read mode
    localparam logic [1:0] CONT_PAT = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        SR_WR,
        Q_ADDR,
        Q_MODE,
        Q_DUMMY,
        Q_DATA,
        IGNORE
    } state_e;

    function automatic logic cont_arm(input logic [7:0] mode);
        return mode[5:4] == CONT_PAT;
    endfunction

endpackage

// File: rtl/qspi_pin_sync.sv
// Synchronizes cs/sclk/io pads into the clk domain and derives
// single-cycle sclk rise/fall and cs fall/rise strobes.
module qspi_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       sclk,
    input  logic [3:0] io_in,
    output logic       cs_s,
    output logic [3:0] io_s,
    output logic       sclk_rise,
    output logic       sclk_fall,
    output logic       cs_fall,
    output logic       cs_rise
);

    // Bit layout {cs, sclk, io[3:0]}; cs resets deasserted
    localparam logic [5:0] RST_VAL = 6'b10_0000;

    logic [5:0] stage_q [SYNC_STAGES];
    logic [1:0] prev_q;
    logic [5:0] cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) stage_q[i] <= RST_VAL;
            prev_q <= RST_VAL[5:4];
        end else begin
            stage_q[0] <= {cs, sclk, io_in};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
            prev_q <= stage_q[SYNC_STAGES-1][5:4];
        end
    end

    assign cur       = stage_q[SYNC_STAGES-1];
    assign cs_s      = cur[5];
    assign io_s      = cur[3:0];
    assign sclk_rise =  cur[4] & ~prev_q[0];
    assign sclk_fall = ~cur[4] &  prev_q[0];
    assign cs_fall   = ~cur[5] &  prev_q[1];
    assign cs_rise   =  cur[5] & ~prev_q[1];

endmodule

// File: rtl/qspi_flash_responder.sv
// QSPI NOR flash target: decodes AB/06/04/01/EB, serves quad reads with
// continuous-read mode from a req/ack byte source with one-byte prefetch.
module qspi_flash_responder
    import qspi_pkg::*;
#(
    parameter int unsigned ADDR_W       = 24,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DUMMY_CLKS   = 4,
    parameter bit          RESET_ASLEEP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              sclk,
    input  logic [3:0]        io_in,
    output logic [3:0]        io_out,
    output logic [3:0]        io_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic [15:0]       sr,
    output logic              qe,
    output logic              asleep,
    output logic              cont_mode,
    output logic              underrun
);

    logic       cs_s, sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic [3:0] io_s;

    qspi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .sclk     (sclk),
        .io_in    (io_in),
        .cs_s     (cs_s),
        .io_s     (io_s),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise)
    );

    state_e            state_q;
    logic [4:0]        cnt_q;
    logic [22:0]       sh_q;
    logic [23:0]       sh_d;
    logic [15:0]       sr_q;
    logic              wel_q, asleep_q, cont_q, underrun_q;
    logic [7:0]        act_q, buf_q, cur_q;
    logic [3:0]        io_out_q, io_oe_q;
    logic              mem_req_q, need_q, disc_q, bvalid_q, hi_q;
    logic [ADDR_W-1:0] mem_addr_q, fetch_q;
    logic              hi_fall, issue;

    always_comb begin
        sh_d = (state_q == CMD || state_q == SR_WR) ? {sh_q[22:0], io_s[0]}
                                                     : {sh_q[19:0], io_s};
        hi_fall = sclk_fall && !cs_s &&
                  ((state_q == Q_DUMMY && cnt_q == 5'(DUMMY_CLKS)) ||
                   (state_q == Q_DATA && !hi_q));
        issue = need_q && !mem_req_q && !cs_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            sr_q       <= '0;
            wel_q      <= 1'b0;
            asleep_q   <= RESET_ASLEEP;
            cont_q     <= 1'b0;
            underrun_q <= 1'b0;
            act_q      <= '0;
            buf_q      <= '0;
            cur_q      <= '0;
            io_out_q   <= '0;
            io_oe_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            fetch_q    <= '0;
            need_q     <= 1'b0;
            disc_q     <= 1'b0;
            bvalid_q   <= 1'b0;
            hi_q       <= 1'b0;
        end else begin
            // A request outstanding across cs high completes but its byte is dropped
            if (mem_req_q && mem_ack) begin
                mem_req_q <= 1'b0;
                disc_q    <= 1'b0;
                if (!disc_q && !cs_s) begin
                    buf_q    <= mem_data;
                    bvalid_q <= 1'b1;
                end
            end else if (issue) begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= fetch_q;
                fetch_q    <= fetch_q + ADDR_W'(1);
                need_q     <= 1'b0;
            end

            if (cs_s) begin
                state_q  <= IDLE;
                io_oe_q  <= '0;
                cnt_q    <= '0;
                need_q   <= 1'b0;
                bvalid_q <= 1'b0;
                hi_q     <= 1'b0;
                if (mem_req_q && !mem_ack) disc_q <= 1'b1;
                if (cs_rise) begin
                    if (state_q == SR_WR) begin
                        wel_q <= 1'b0;
                        if (cnt_q == 5'd16) sr_q <= {sh_q[7:0], sh_q[15:8]};
                    end
                    case (act_q)
                        OP_RDP:  asleep_q <= 1'b0;
                        OP_WREN: wel_q    <= 1'b1;
                        OP_WRDI: wel_q    <= 1'b0;
                        default: ;
                    endcase
                    act_q <= '0;
                end
            end else begin
                case (state_q)
                    IDLE: if (cs_fall) begin
                        cnt_q   <= '0;
                        state_q <= cont_q ? Q_ADDR : CMD;
                    end
                    CMD: if (sclk_rise) begin
                        sh_q  <= sh_d[22:0];
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_q   <= '0;
                            state_q <= IGNORE;
                            if (asleep_q) begin
                                if (sh_d[7:0] == OP_RDP) act_q <= OP_RDP;
                            end else begin
                                case (sh_d[7:0])
                                    OP_RDP, OP_WREN, OP_WRDI: act_q <= sh_d[7:0];
                                    OP_WRSR:  if (wel_q) state_q <= SR_WR;
                                    OP_QREAD: if (sr_q[9]) state_q <= Q_ADDR;
                                    default: ;
                                endcase
                            end
                        end
                    end
                    SR_WR: if (sclk_rise) begin
                        sh_q <= sh_d[22:0];
                        if (cnt_q != 5'd17) cnt_q <= cnt_q + 5'd1;
                    end
                    Q_ADDR: if (sclk_rise) begin
                        sh_q  <= sh_d[22:0];
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd5) begin
                            fetch_q <= ADDR_W'(sh_d);
                            need_q  <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= Q_MODE;
                        end
                    end
                    Q_MODE: if (sclk_rise) begin
                        sh_q  <= sh_d[22:0];
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd1) begin
                            cont_q  <= cont_arm(sh_d[7:0]);
                            cnt_q   <= '0;
                            state_q <= Q_DUMMY;
                        end
                    end
                    Q_DUMMY: begin
                        if (sclk_rise && cnt_q != '1) cnt_q <= cnt_q + 5'd1;
                        if (hi_fall) state_q <= Q_DATA;
                    end
                    default: ;
                endcase

                // High nibble consumes the prefetch buffer and requests the next byte
                if (hi_fall) begin
                    io_oe_q <= '1;
                    hi_q    <= 1'b1;
                    if (bvalid_q) begin
                        io_out_q <= buf_q[7:4];
                        cur_q    <= buf_q;
                        bvalid_q <= 1'b0;
                        need_q   <= 1'b1;
                    end else begin
                        io_out_q   <= '0;
                        cur_q      <= '0;
                        underrun_q <= 1'b1;
                    end
                end else if (sclk_fall && state_q == Q_DATA && hi_q) begin
                    io_out_q <= cur_q[3:0];
                    hi_q     <= 1'b0;
                end
            end
        end
    end

    assign io_out    = io_out_q;
    assign io_oe     = io_oe_q;
    assign mem_addr  = mem_addr_q;
    assign mem_req   = mem_req_q;
    assign sr        = sr_q;
    assign qe        = sr_q[9];
    assign asleep    = asleep_q;
    assign cont_mode = cont_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench: bit-bangs a mode-0 QSPI master and serves a byte memory.
module tb_qspi_flash_responder;

    localparam int HALF = 4;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst, cs, sclk;
    logic [3:0]  io_in, io_out, io_oe;
    logic [23:0] mem_addr;
    logic        mem_req, mem_ack;
    logic [7:0]  mem_data;
    logic [15:0] sr;
    logic        qe, asleep, cont_mode, underrun;

    int errors = 0;
    int checks = 0;

    logic [23:0] req_log[$];
    logic [23:0] mem_a;
    bit          slow = 1'b0;
    logic [3:0]  nv, noe;

    qspi_flash_responder #(
        .ADDR_W(24), .SYNC_STAGES(SYNC), .DUMMY_CLKS(4), .RESET_ASLEEP(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .io_in(io_in),
        .io_out(io_out), .io_oe(io_oe), .mem_addr(mem_addr), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_data(mem_data), .sr(sr), .qe(qe),
        .asleep(asleep), .cont_mode(cont_mode), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h8F428F: return 8'h02;
            24'h8F4290: return 8'h01;
            24'h8F4291: return 8'hFF;
            24'h8F4292: return 8'h7A;
            24'hFFFFFE: return 8'h96;
            24'hFFFFFF: return 8'hC3;
            24'h000000: return 8'h5A;
            default:    return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    // Byte source: acks two clocks after a request (40 at FFFFFF when slow)
    initial begin
        mem_ack  = 1'b0;
        mem_data = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
                mem_a = mem_addr;
                req_log.push_back(mem_a);
                repeat ((slow && mem_a == 24'hFFFFFF) ? 40 : 2) @(negedge clk);
                chk("mem_addr_stable", mem_addr, mem_a);
                mem_data = mem_byte(mem_a);
                mem_ack  = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        tick(HALF); sclk = 1'b1; tick(HALF); sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            io_in[0] = b[i];
            pulse();
        end
    endtask

    task automatic send_nib(input logic [3:0] n);
        io_in = n;
        pulse();
    endtask

    task automatic read_nib(output logic [3:0] v, output logic [3:0] oe);
        tick(HALF); sclk = 1'b1; v = io_out; oe = io_oe;
        tick(HALF); sclk = 1'b0;
    endtask

    task automatic stop();
        cs = 1'b1; io_in = '0; tick(SYNC + 2);
    endtask

    task automatic xfer3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int nbits);
        cs = 1'b0;
        send_bits(b0, 8);
        send_bits(b1, (nbits > 16) ? 8 : nbits - 8);
        if (nbits > 16) send_bits(b2, (nbits > 24) ? 8 : nbits - 16);
        if (nbits > 24) send_bits(8'hFF, nbits - 24);
        stop();
    endtask

    task automatic xfer1(input logic [7:0] b0);
        cs = 1'b0; send_bits(b0, 8); stop();
    endtask

    task automatic addr_mode_dummy(input logic [23:0] a, input logic [7:0] m);
        for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
        send_nib(m[7:4]);
        send_nib(m[3:0]);
        io_in = '0;
        for (int d = 0; d < 4; d++) begin
            tick(HALF); sclk = 1'b1;
            chk("dummy_oe", io_oe, 4'h0);
            tick(HALF); sclk = 1'b0;
        end
    endtask

    task automatic read_bytes(input logic [23:0] start, input int n);
        logic [7:0]  e;
        logic [23:0] a;
        for (int k = 0; k < n; k++) begin
            a = start + 24'(k);
            e = mem_byte(a);
            read_nib(nv, noe);
            chk("data_hi", nv, e[7:4]);
            chk("data_oe", noe, 4'hF);
            read_nib(nv, noe);
            chk("data_lo", nv, e[3:0]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cs = 1'b1; sclk = 1'b0; io_in = '0;
        tick(3);
        rst = 1'b0;
        tick(2);
        chk("rst_io_oe", io_oe, 4'h0);
        chk("rst_io_out", io_out, 4'h0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 24'h0);
        chk("rst_sr", sr, 16'h0);
        chk("rst_asleep", asleep, 1'b1);
        chk("rst_cont", cont_mode, 1'b0);
        chk("rst_underrun", underrun, 1'b0);

        // Asleep: WREN and quad read ignored
        xfer1(8'h06);
        cs = 1'b0;
        send_bits(8'hEB, 8);
        for (int i = 0; i < 10; i++) send_nib(4'(i + 3));
        chk("sleep_io_oe", io_oe, 4'h0);
        chk("sleep_mem_req", mem_req, 1'b0);
        stop();
        chk("sleep_asleep", asleep, 1'b1);
        chk("sleep_no_reqs", req_log.size(), 0);

        // Wake, then WRSR without WREN has no effect
        xfer1(8'hAB);
        chk("wake_asleep", asleep, 1'b0);
        xfer3(8'h01, 8'h11, 8'h22, 24);
        chk("wrsr_no_wel", sr, 16'h0000);
        xfer1(8'h06);
        xfer3(8'h01, 8'h80, 8'h02, 24);
        chk("wrsr_sr", sr, 16'h0280);
        chk("wrsr_qe", qe, 1'b1);
        xfer3(8'h01, 8'h33, 8'h44, 24);
        chk("wel_cleared", sr, 16'h0280);

        // Short and long WRSR leave sr alone; short one still clears wel
        xfer1(8'h06);
        xfer3(8'h01, 8'h55, 8'hAA, 20);
        chk("wrsr_short", sr, 16'h0280);
        xfer3(8'h01, 8'h66, 8'h00, 24);
        chk("wel_clr_short", sr, 16'h0280);
        xfer1(8'h06);
        xfer3(8'h01, 8'h55, 8'hAA, 25);
        chk("wrsr_long", sr, 16'h0280);
        xfer1(8'h06);
        xfer3(8'h01, 8'h81, 8'h02, 24);
        chk("wrsr_again", sr, 16'h0281);

        // Quad read arming continuous mode
        req_log.delete();
        cs = 1'b0;
        send_bits(8'hEB, 8);
        addr_mode_dummy(24'h8F428F, 8'h20);
        read_bytes(24'h8F428F, 4);
        stop();
        chk("cont_armed", cont_mode, 1'b1);
        chk("req_count", req_log.size() >= 4, 1'b1);
        if (req_log.size() >= 4)
            for (int i = 0; i < 4; i++) chk("req_addr", req_log[i], 24'h8F428F + 24'(i));

        // Continuous mode: no opcode, wrap at top of address space, disarm
        cs = 1'b0;
        addr_mode_dummy(24'hFFFFFF, 8'hFF);
        read_bytes(24'hFFFFFF, 2);
        stop();
        chk("cont_cleared", cont_mode, 1'b0);
        chk("no_underrun_yet", underrun, 1'b0);

        // Slow memory at FFFFFF: underrun, cs raised with request outstanding
        slow = 1'b1;
        cs = 1'b0;
        send_bits(8'hEB, 8);
        addr_mode_dummy(24'hFFFFFE, 8'h00);
        read_bytes(24'hFFFFFE, 1);
        read_nib(nv, noe);
        chk("underrun_hi", nv, 4'h0);
        read_nib(nv, noe);
        chk("underrun_lo", nv, 4'h0);
        cs = 1'b1; io_in = '0;
        tick(SYNC + 2);
        chk("cs_hi_io_oe", io_oe, 4'h0);
        chk("underrun_flag", underrun, 1'b1);
        chk("req_pending", mem_req, 1'b1);
        chk("req_pending_addr", mem_addr, 24'hFFFFFF);
        for (int t = 0; t < 100 && mem_req; t++) tick(1);
        chk("req_dropped", mem_req, 1'b0);
        slow = 1'b0;
        tick(4);

        // Fresh read after the discarded byte
        cs = 1'b0;
        send_bits(8'hEB, 8);
        addr_mode_dummy(24'h000010, 8'h00);
        read_bytes(24'h000010, 1);
        stop();
        chk("underrun_sticky", underrun, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
